// File: rtl/reg_file_sb_pkg.sv
// Shared pipeline constants: default register-file geometry used by decode, hazard and regfile.
// Latency: n/a (constants only).
// Backpressure: n/a.
package reg_file_sb_pkg;

   localparam int DEF_DATA_W = 32;   // architectural register width
   localparam int DEF_ADDR_W = 5;    // 32 architectural registers
   localparam int DEF_NREAD  = 2;    // read ports per issue slot

endpackage : reg_file_sb_pkg

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an outstanding producer, plus a popcount.
// Latency: set/clear visible on o_busy and o_busy_count one cycle after the request.
// Backpressure: none; issue and writeback are accepted every cycle.
//
// Ports:
//   clk, rst         sole clock, synchronous active-high reset (clears all busy bits)
//   i_set_vld/_idx   issue: mark register busy
//   i_clr_vld/_idx   writeback: mark register free
//   o_busy           registered busy vector, one bit per register
//   o_busy_count     number of set bits in o_busy
module reg_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_set_vld,
   input  logic [ADDR_W-1:0]     i_set_idx,
   input  logic                  i_clr_vld,
   input  logic [ADDR_W-1:0]     i_clr_idx,
   output logic [2**ADDR_W-1:0]  o_busy,
   output logic [ADDR_W:0]       o_busy_count
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] r_busy;
   logic [ADDR_W:0]  r_busy_count;
   logic [DEPTH-1:0] w_busy_nxt;
   logic [ADDR_W:0]  w_count_nxt;

   always_comb begin
      w_busy_nxt = r_busy;
      // Clear before set: a same-cycle issue to the register being written back
      // is a newer producer, so the busy bit must survive.
      if (i_clr_vld) w_busy_nxt[i_clr_idx] = 1'b0;
      if (i_set_vld) w_busy_nxt[i_set_idx] = 1'b1;
      if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;

      // Count the next-state vector so the count register tracks r_busy exactly.
      w_count_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_count_nxt = w_count_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy       <= '0;
         r_busy_count <= '0;
      end else begin
         r_busy       <= w_busy_nxt;
         r_busy_count <= w_count_nxt;
      end
   end

   assign o_busy       = r_busy;
   assign o_busy_count = r_busy_count;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Register file with write-through bypass and per-register busy scoreboard.
// Latency: reads combinational (same-cycle writeback bypassed); writes/busy commit on next edge.
// Backpressure: none; every port is accepted every cycle, hazards are reported via readBusy.
//
// Ports:
//   clk, rst               sole clock, synchronous active-high reset (clears data and busy)
//   regWrite/writeReg/Data writeback port
//   issueValid/issueReg    issued instruction that will later write issueReg
//   readAddr/readData      NREAD packed read ports, port k at slice k
//   readBusy               port k's register has an outstanding producer
//   busyCount              number of busy registers
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NREAD    = DEF_NREAD,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     regWrite,
   input  logic [ADDR_W-1:0]        writeReg,
   input  logic [DATA_W-1:0]        writeData,
   input  logic                     issueValid,
   input  logic [ADDR_W-1:0]        issueReg,
   input  logic [NREAD*ADDR_W-1:0]  readAddr,
   output logic [NREAD*DATA_W-1:0]  readData,
   output logic [NREAD-1:0]         readBusy,
   output logic [ADDR_W:0]          busyCount
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  w_busy;
   logic              w_wr_en;

   // Writes to the hardwired zero register are dropped so r_mem[0] stays 0.
   assign w_wr_en = regWrite && !((ZERO_REG != 0) && (writeReg == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[writeReg] <= writeData;
      end
   end

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .i_set_vld    (issueValid),
      .i_set_idx    (issueReg),
      .i_clr_vld    (regWrite),
      .i_clr_idx    (writeReg),
      .o_busy       (w_busy),
      .o_busy_count (busyCount)
   );

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_zero;
      logic              w_hit;
      logic [DATA_W-1:0] w_data;

      assign w_addr = readAddr[k*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
      assign w_hit  = regWrite && (writeReg == w_addr);

      // Zero register beats the bypass; otherwise a same-cycle writeback wins over storage.
      assign w_data = w_zero ? '0 : (w_hit ? writeData : r_mem[w_addr]);

      assign readData[k*DATA_W +: DATA_W] = w_data;
      // The writeback that is being bypassed is the producer, so it hides the busy bit.
      assign readBusy[k] = w_busy[w_addr] && !w_hit;
   end

endmodule : reg_file_sb
